// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// Multi-cycle word data memory for the MEM stage: IDLE -> WAIT -> RESP, one access at a time.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned accesses complete with resp_err and never touch the array.
module data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  stall
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            count_q, count_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  misalign_q, misalign_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  acc_en;
   logic                  acc_write;
   logic                  acc_misalign;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic                  mem_we;
   logic                  req_misalign;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic                  unused_addr_bits;

   assign req_idx          = req_addr[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^req_addr;

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_misalign = (req_addr[1:0] != 2'b00);
`else
   assign req_misalign = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      write_d      = write_q;
      idx_d        = idx_q;
      misalign_d   = misalign_q;
      wdata_d      = wdata_q;
      acc_en       = 1'b0;
      acc_write    = write_q;
      acc_idx      = idx_q;
      acc_misalign = misalign_q;
      acc_wdata    = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               write_d    = req_write;
               idx_d      = req_idx;
               misalign_d = req_misalign;
               wdata_d    = req_wdata;
               // With single-edge latency the access happens on the accept edge itself
               if (LATENCY == 1) begin
                  state_d      = ST_RESP;
                  acc_en       = 1'b1;
                  acc_write    = req_write;
                  acc_idx      = req_idx;
                  acc_misalign = req_misalign;
                  acc_wdata    = req_wdata;
               end else begin
                  state_d = ST_WAIT;
                  count_d = 4'(LATENCY - 2);
               end
            end
         end
         ST_WAIT: begin
            if (count_q == 4'd0) begin
               state_d = ST_RESP;
               acc_en  = 1'b1;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
      resp_err_d   = acc_en && acc_misalign;
      resp_rdata_d = '0;
      if (acc_en && !acc_write && !acc_misalign) begin
         resp_rdata_d = mem[acc_idx];
      end
      // rst_n gate keeps a single-edge-latency store from landing while reset is held
      mem_we = acc_en && acc_write && !acc_misalign && rst_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         write_q      <= 1'b0;
         idx_q        <= '0;
         misalign_q   <= 1'b0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         write_q      <= write_d;
         idx_q        <= idx_d;
         misalign_q   <= misalign_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign stall      = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// Bench: three responders (LATENCY 2, 1, 15) share one request stream; a timeline model
// predicts each one's handshake, stall and response data every cycle.
module tb_data_mem_responder;
   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 8;

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
   endfunction

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready [N];
   logic          resp_valid [N];
   logic          resp_err [N];
   logic          stall [N];
   logic [DW-1:0] resp_rdata [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      data_mem_responder #(
         .DATA_WIDTH(DW),
         .ADDR_WIDTH(AW),
         .LATENCY(gi == 0 ? 2 : (gi == 1 ? 1 : 15))
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .req_valid(req_valid),
         .req_ready(req_ready[gi]),
         .req_write(req_write),
         .req_addr(req_addr),
         .req_wdata(req_wdata),
         .resp_valid(resp_valid[gi]),
         .resp_rdata(resp_rdata[gi]),
         .resp_err(resp_err[gi]),
         .stall(stall[gi])
      );
   end

   task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %h expected %h", name, i, act, exp);
      end
   endtask

   // ---------------- reference model: per-instance timeline + word array ----------------
   bit            m_busy [N];
   bit            m_resp [N];
   int            m_left [N];
   bit            m_write [N];
   logic [31:0]   m_addr [N];
   logic [DW-1:0] m_wdata [N];
   logic [DW-1:0] e_rdata [N];
   bit            e_err [N];
   bit            e_known [N];
   logic [DW-1:0] ref_mem [N][256];
   bit            ref_ok [N][256];

   task automatic perform(input int i, input bit wr, input logic [31:0] a, input logic [DW-1:0] wd);
      int  idx;
      bit  mis;
      idx = int'((a / 4) % 256);
      mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis = (a % 4) != 0;
`endif
      e_err[i]   = mis;
      e_known[i] = 1'b1;
      e_rdata[i] = '0;
      if (!mis) begin
         if (wr) begin
            ref_mem[i][idx] = wd;
            ref_ok[i][idx]  = 1'b1;
         end else begin
            e_rdata[i] = ref_mem[i][idx];
            e_known[i] = ref_ok[i][idx];
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            m_busy[i] = 1'b0;
            m_resp[i] = 1'b0;
         end else if (m_resp[i]) begin
            m_resp[i] = 1'b0;
         end else if (m_busy[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
               perform(i, m_write[i], m_addr[i], m_wdata[i]);
               m_busy[i] = 1'b0;
               m_resp[i] = 1'b1;
            end
         end else if (req_valid) begin
            m_write[i] = req_write;
            m_addr[i]  = req_addr;
            m_wdata[i] = req_wdata;
            m_left[i]  = lat_of(i) - 1;
            if (m_left[i] == 0) begin
               perform(i, req_write, req_addr, req_wdata);
               m_resp[i] = 1'b1;
            end else begin
               m_busy[i] = 1'b1;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            chk("rst_ready", i, req_ready[i], 1);
            chk("rst_valid", i, resp_valid[i], 0);
            chk("rst_rdata", i, resp_rdata[i], 0);
            chk("rst_err", i, resp_err[i], 0);
            chk("rst_stall", i, stall[i], req_valid);
         end else begin
            chk("ready", i, req_ready[i], !m_busy[i] && !m_resp[i]);
            chk("resp_valid", i, resp_valid[i], m_resp[i]);
            chk("stall", i, stall[i], !m_resp[i] && (m_busy[i] || req_valid));
            if (m_resp[i]) begin
               if (e_known[i]) chk("rdata", i, resp_rdata[i], e_rdata[i]);
               chk("err", i, resp_err[i], e_err[i]);
               $display("txn inst%0d %s addr=%h rdata=%h err=%0d", i,
                        m_write[i] ? "store" : "load ", m_addr[i], resp_rdata[i], resp_err[i]);
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   int            t_lat [N];
   logic [DW-1:0] t_rdata [N];
   logic          t_err [N];

   // Starts just after a posedge with every instance idle; returns after all have responded.
   task automatic txn(input bit wr, input logic [31:0] addr, input logic [DW-1:0] wd);
      bit done;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      for (int i = 0; i < N; i++) t_lat[i] = 0;
      @(negedge clk);
      chk("accept_stall", 0, stall[0], 1);
      chk("accept_ready", 0, req_ready[0], 1);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) req_valid = 1'b0;
         @(negedge clk);
         done = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (resp_valid[i] && t_lat[i] == 0) begin
               t_lat[i]   = k;
               t_rdata[i] = resp_rdata[i];
               t_err[i]   = resp_err[i];
            end
            if (t_lat[i] == 0) done = 1'b0;
         end
         if (done) break;
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [5:0]  rv_pat, rdy_pat;
   logic [31:0] r;

   initial begin
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("lit_rst_ready", 0, req_ready[0], 1);
      chk("lit_rst_valid", 0, resp_valid[0], 0);
      chk("lit_rst_rdata", 0, resp_rdata[0], 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // store then load, latency pinned for all three instances
      txn(1'b1, 32'h10, 32'hDEADBEEF);
      chk("lit_lat2", 0, t_lat[0], 2);
      chk("lit_lat1", 1, t_lat[1], 1);
      chk("lit_lat15", 2, t_lat[2], 15);
      chk("lit_store_rdata", 0, t_rdata[0], 0);
      txn(1'b0, 32'h10, 32'h0);
      chk("lit_load_rdata", 0, t_rdata[0], 32'hDEADBEEF);
      chk("lit_load_rdata", 2, t_rdata[2], 32'hDEADBEEF);
      chk("lit_load_lat", 0, t_lat[0], 2);

      // aliasing: 0x400 wraps onto word 0
      txn(1'b1, 32'h000, 32'h1111);
      txn(1'b0, 32'h400, 32'h0);
      chk("lit_alias", 0, t_rdata[0], 32'h1111);

      // misaligned load and store
      txn(1'b0, 32'h13, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("lit_mis_load_rdata", 0, t_rdata[0], 0);
      chk("lit_mis_load_err", 0, t_err[0], 1);
`else
      chk("lit_mis_load_rdata", 0, t_rdata[0], 32'hDEADBEEF);
      chk("lit_mis_load_err", 0, t_err[0], 0);
`endif
      txn(1'b1, 32'h13, 32'h5555);
      txn(1'b0, 32'h10, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("lit_mis_store", 0, t_rdata[0], 32'hDEADBEEF);
`else
      chk("lit_mis_store", 0, t_rdata[0], 32'h5555);
`endif

      // reset in the middle of a pending store
      txn(1'b1, 32'h20, 32'h12345678);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      chk("lit_midrst_ready", 0, req_ready[0], 1);
      chk("lit_midrst_valid", 0, resp_valid[0], 0);
      chk("lit_midrst_stall", 0, stall[0], 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      txn(1'b0, 32'h20, 32'h0);
      chk("lit_midrst_old", 0, t_rdata[0], 32'h12345678);
      chk("lit_midrst_lat1", 1, t_rdata[1], 32'hCAFEF00D);

      // back-to-back with req_valid held
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h10;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         rv_pat[k-1]  = resp_valid[0];
         rdy_pat[k-1] = req_ready[0];
      end
      chk("lit_b2b_valid", 0, rv_pat, 6'b010010);
      chk("lit_b2b_ready", 0, rdy_pat, 6'b100100);
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         r         = $urandom();
         req_valid = ($urandom_range(0, 99) < 60);
         req_write = ($urandom_range(0, 99) < 40);
         req_wdata = $urandom();
         req_addr  = (r & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 7) == 0) req_addr = req_addr | 32'($urandom_range(0, 3));
         rst_n = ($urandom_range(0, 399) != 0);
         @(posedge clk);
         #1;
      end
      rst_n     = 1'b1;
      req_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
